// File: rtl/pipeline_operand_packer_if.sv
// Stream bundle between the operand source, the packer and the adder-tree input stage.
// The master side drives operand beats and consumes vectors; the slave side is the packer.
interface pipeline_operand_packer_if #(
    parameter int WIDTH     = 32,
    parameter int INPUT_NUM = 8,
    parameter int CNT_W     = $clog2(INPUT_NUM) + 1
);
    logic                                in_valid;
    logic                                in_ready;
    logic [WIDTH-1:0]                    in_data;
    logic                                in_last;
    logic                                out_valid;
    logic                                out_ready;
    logic [INPUT_NUM-1:0][WIDTH-1:0]     out_data;
    logic [CNT_W-1:0]                    out_lanes;
    logic                                out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_lanes, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_lanes, out_last
    );
endinterface

// File: rtl/pipeline_operand_packer.sv
// Serial-to-parallel packer: gathers INPUT_NUM operands into one lane vector, zero-pads
// partial vectors closed by in_last, and holds one finished vector while the output is busy.
module pipeline_operand_packer #(
    parameter int WIDTH     = 32,
    parameter int INPUT_NUM = 8,
    parameter int CNT_W     = $clog2(INPUT_NUM) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    pipeline_operand_packer_if.slave  bus
);
    localparam int IDX_W = $clog2(INPUT_NUM);

    typedef logic [INPUT_NUM-1:0][WIDTH-1:0] vec_t;

    vec_t             fill_buf_r;
    logic [CNT_W-1:0] fill_cnt_r;
    logic             pending_r;
    logic [CNT_W-1:0] pend_lanes_r;
    logic             pend_last_r;

    vec_t             out_data_r;
    logic [CNT_W-1:0] out_lanes_r;
    logic             out_last_r;
    logic             out_valid_r;

    logic             accept_s;
    logic             slot_free_s;
    logic             at_end_s;
    logic             close_s;
    logic             load_pend_s;
    logic             load_new_s;
    logic [CNT_W-1:0] close_lanes_s;
    logic [IDX_W-1:0] idx_s;
    vec_t             close_vec_s;

    // Handshake decode and the vector as it looks with the current beat merged in.
    always_comb begin
        accept_s      = bus.in_valid & ~pending_r;
        slot_free_s   = ~out_valid_r | bus.out_ready;
        at_end_s      = (fill_cnt_r == CNT_W'(INPUT_NUM - 1));
        close_s       = accept_s & (at_end_s | bus.in_last);
        load_pend_s   = pending_r & slot_free_s;
        load_new_s    = close_s & slot_free_s;
        close_lanes_s = fill_cnt_r + CNT_W'(1);
        idx_s         = fill_cnt_r[IDX_W-1:0];
        close_vec_s   = fill_buf_r;
        for (int i = 0; i < INPUT_NUM; i++) begin
            // Lanes above the write index are still zero from the last clear: that is the padding.
            if (IDX_W'(i) == idx_s) begin
                close_vec_s[i] = bus.in_data;
            end else begin
                close_vec_s[i] = fill_buf_r[i];
            end
        end
    end

    // Fill buffer, lane counter and the held (pending) vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_buf_r   <= '0;
            fill_cnt_r   <= '0;
            pending_r    <= 1'b0;
            pend_lanes_r <= '0;
            pend_last_r  <= 1'b0;
        end else if (load_pend_s) begin
            fill_buf_r   <= '0;
            pending_r    <= 1'b0;
        end else if (close_s) begin
            fill_cnt_r   <= '0;
            if (slot_free_s) begin
                fill_buf_r   <= '0;
            end else begin
                fill_buf_r   <= close_vec_s;
                pending_r    <= 1'b1;
                pend_lanes_r <= close_lanes_s;
                pend_last_r  <= bus.in_last;
            end
        end else if (accept_s) begin
            fill_buf_r[idx_s] <= bus.in_data;
            fill_cnt_r        <= close_lanes_s;
        end else begin
            fill_cnt_r   <= fill_cnt_r;
        end
    end

    // Output slot: a held vector has priority; a load at the transfer edge keeps out_valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_lanes_r <= '0;
            out_last_r  <= 1'b0;
        end else if (load_pend_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= fill_buf_r;
            out_lanes_r <= pend_lanes_r;
            out_last_r  <= pend_last_r;
        end else if (load_new_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= close_vec_s;
            out_lanes_r <= close_lanes_s;
            out_last_r  <= bus.in_last;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = ~pending_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_lanes = out_lanes_r;
    assign bus.out_last  = out_last_r;
endmodule

// File: tb/tb_pipeline_operand_packer.sv
// Directed table plus hand-written corner sequences and a randomised scoreboard run
// for pipeline_operand_packer with WIDTH=32, INPUT_NUM=8.
module tb_pipeline_operand_packer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_operand_packer_if #(.WIDTH(32), .INPUT_NUM(8), .CNT_W(4)) bus ();

    pipeline_operand_packer #(.WIDTH(32), .INPUT_NUM(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        r;
        logic        iv;
        logic [31:0] d;
        logic        il;
        logic        ordy;
        logic        eir;
        logic        eov;
        logic [3:0]  elanes;
        logic        elast;
        logic        chkd;
        logic [255:0] edata;
    } vec_t;

    typedef struct {
        logic [255:0] d;
        logic [3:0]   n;
        logic         l;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic iv, input logic [31:0] d, input logic il,
                         input logic ordy);
        rst           = r;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_last   = il;
        bus.out_ready = ordy;
    endtask

    function automatic logic [255:0] vec_seq(input logic [31:0] base, input int n);
        logic [7:0][31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = base + 32'(i);
        return v;
    endfunction

    task automatic add(input logic r, input logic iv, input logic [31:0] d, input logic il,
                       input logic ordy, input logic eir, input logic eov, input logic [3:0] el,
                       input logic elast, input logic chkd, input logic [255:0] ed);
        vec_t v;
        v.r = r; v.iv = iv; v.d = d; v.il = il; v.ordy = ordy;
        v.eir = eir; v.eov = eov; v.elanes = el; v.elast = elast; v.chkd = chkd; v.edata = ed;
        tbl.push_back(v);
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [3:0] n,
                           input logic l, input logic [255:0] d);
        chk({tag, "_out_valid"}, 256'(bus.out_valid), 256'(ov));
        chk({tag, "_out_lanes"}, 256'(bus.out_lanes), 256'(n));
        chk({tag, "_out_last"},  256'(bus.out_last),  256'(l));
        chk({tag, "_out_data"},  256'(bus.out_data),  d);
    endtask

    initial begin
        logic [7:0][31:0] cur;
        int               cur_n;
        int               sent;
        logic             acc;
        logic             xfer;
        exp_t             e;

        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);

        // Reset state, partial vector on in_last, single-beat vector, hold, full vector with last.
        add(1'b1, 1'b0, 32'd0, 1'b0, 1'b1,  1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 256'd0);
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b1,  1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 256'd0);
        add(1'b0, 1'b1, 32'd5, 1'b0, 1'b1,  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 256'd0);
        add(1'b0, 1'b1, 32'd6, 1'b0, 1'b1,  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 256'd0);
        add(1'b0, 1'b1, 32'd7, 1'b1, 1'b1,  1'b1, 1'b1, 4'd3, 1'b1, 1'b1, vec_seq(32'd5, 3));
        add(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1,
            vec_seq(32'hDEADBEEF, 1));
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0,  1'b1, 1'b1, 4'd1, 1'b1, 1'b1,
            vec_seq(32'hDEADBEEF, 1));
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b1,  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 256'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) add(1'b0, 1'b1, 32'h10 + 32'(i), 1'b1, 1'b1, 1'b1, 1'b1, 4'd8, 1'b1,
                            1'b1, vec_seq(32'h10, 8));
            else        add(1'b0, 1'b1, 32'h10 + 32'(i), 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0,
                            1'b0, 256'd0);
        end
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b1,  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 256'd0);
        // Close while slot busy -> pending; next beat refused; pending vector loads on out_ready.
        add(1'b0, 1'b1, 32'h21, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, vec_seq(32'h21, 1));
        add(1'b0, 1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1, vec_seq(32'h21, 1));
        add(1'b0, 1'b1, 32'h23, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1, vec_seq(32'h21, 1));
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b1,  1'b1, 1'b1, 4'd1, 1'b1, 1'b1, vec_seq(32'h22, 1));
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b1,  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 256'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].il, tbl[i].ordy);
            step();
            chk($sformatf("tbl%0d_in_ready", i),  256'(bus.in_ready),  256'(tbl[i].eir));
            chk($sformatf("tbl%0d_out_valid", i), 256'(bus.out_valid), 256'(tbl[i].eov));
            if (tbl[i].chkd) begin
                chk($sformatf("tbl%0d_out_lanes", i), 256'(bus.out_lanes), 256'(tbl[i].elanes));
                chk($sformatf("tbl%0d_out_last", i),  256'(bus.out_last),  256'(tbl[i].elast));
                chk($sformatf("tbl%0d_out_data", i),  256'(bus.out_data),  tbl[i].edata);
            end
        end

        // Full-rate streaming 1..16 with out_ready high.
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 1'b1, 32'(k), 1'b0, 1'b1);
            step();
            chk($sformatf("stream_k%0d_in_ready", k), 256'(bus.in_ready), 256'd1);
            if (k == 8)       chk_out("stream_v1", 1'b1, 4'd8, 1'b0, vec_seq(32'd1, 8));
            else if (k == 16) chk_out("stream_v2", 1'b1, 4'd8, 1'b0, vec_seq(32'd9, 8));
            else chk($sformatf("stream_k%0d_out_valid", k), 256'(bus.out_valid), 256'd0);
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        step();

        // Backpressure: stream 1..16 with out_ready low, then release.
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 1'b1, 32'(k), 1'b0, 1'b0);
            step();
            chk($sformatf("bp_k%0d_in_ready", k), 256'(bus.in_ready), 256'(k < 16));
            if (k >= 8) chk_out($sformatf("bp_k%0d", k), 1'b1, 4'd8, 1'b0, vec_seq(32'd1, 8));
            else chk($sformatf("bp_k%0d_out_valid", k), 256'(bus.out_valid), 256'd0);
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 32'd17, 1'b1, 1'b0);
            step();
            chk("bp_stall_in_ready", 256'(bus.in_ready), 256'd0);
            chk_out("bp_stall", 1'b1, 4'd8, 1'b0, vec_seq(32'd1, 8));
        end
        drive(1'b0, 1'b1, 32'd17, 1'b1, 1'b1);
        step();
        chk("bp_release_in_ready", 256'(bus.in_ready), 256'd1);
        chk_out("bp_release", 1'b1, 4'd8, 1'b0, vec_seq(32'd9, 8));
        step();
        chk_out("bp_beat17", 1'b1, 4'd1, 1'b1, vec_seq(32'd17, 1));
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        step();
        chk("bp_drained_out_valid", 256'(bus.out_valid), 256'd0);

        // Reset mid-vector discards the partial beats.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 32'hB0 + 32'(k), 1'b0, 1'b1);
            step();
        end
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        step();
        chk("rst_mid_in_ready", 256'(bus.in_ready), 256'd1);
        chk_out("rst_mid", 1'b0, 4'd0, 1'b0, 256'd0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, 32'hA0 + 32'(k), 1'b0, 1'b1);
            step();
            if (k == 7) chk_out("rst_after", 1'b1, 4'd8, 1'b0, vec_seq(32'hA0, 8));
            else chk($sformatf("rst_after_k%0d_out_valid", k), 256'(bus.out_valid), 256'd0);
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        step();
        chk("rst_after_drain_out_valid", 256'(bus.out_valid), 256'd0);

        // Random handshakes against a bench-side packing model.
        cur   = '0;
        cur_n = 0;
        sent  = 0;
        for (int cyc = 0; cyc < 20000 && (sent < 1000 || exp_q.size() != 0); cyc++) begin
            bus.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            bus.in_data   = 32'h5000_0000 + 32'(sent);
            bus.in_last   = (sent == 999) || ($urandom_range(0, 7) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            rst           = 1'b0;
            #1;
            acc  = bus.in_valid && bus.in_ready;
            xfer = bus.out_valid && bus.out_ready;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious_vector", 256'd1, 256'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_data",  256'(bus.out_data),  e.d);
                    chk("rnd_lanes", 256'(bus.out_lanes), 256'(e.n));
                    chk("rnd_last",  256'(bus.out_last),  256'(e.l));
                end
            end
            if (acc) begin
                cur[cur_n] = bus.in_data;
                cur_n++;
                sent++;
                if (cur_n == 8 || bus.in_last) begin
                    e.d = cur;
                    e.n = 4'(cur_n);
                    e.l = bus.in_last;
                    exp_q.push_back(e);
                    cur   = '0;
                    cur_n = 0;
                end
            end
            step();
        end
        chk("rnd_beats_sent", 256'(sent), 256'd1000);
        chk("rnd_all_vectors_seen", 256'(exp_q.size()), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
